// File: rtl/reg_file_bypass.sv
// Parametrised register file: two registered read ports, one byte-enabled write port,
// same-edge write-to-read bypass, optional hardwired-zero r0, asynchronous array clear.
module reg_file_bypass #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data
);

  // Post-write value of every register; the read muxes select from this, which is
  // exactly the bypassed view of the array.
  logic [DATA_W-1:0] rows_d [DEPTH];

  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              rd_valid_q, rd_valid_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_row
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign rows_d[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] word_q, word_d;

        always_comb begin
          word_d = word_q;
          if (wr_en && (wr_addr == ADDR_W'(gi))) begin
            for (int b = 0; b < BE_W; b++) begin
              if (wr_be[b]) word_d[8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) word_q <= '0;
          else     word_q <= word_d;
        end

        assign rows_d[gi] = word_d;
      end
    end
  endgenerate

  // Addresses at or beyond DEPTH match no row and therefore read as zero.
  always_comb begin
    rd_data1_d = '0;
    rd_data2_d = '0;
    rd_valid_d = rd_en;
    if (rd_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr1 == ADDR_W'(i)) rd_data1_d = rows_d[i];
        if (rd_addr2 == ADDR_W'(i)) rd_data2_d = rows_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
- Parametrised successor to the team's 16x16 register file.
- Two registered read ports and one byte-enabled write port with its own write address.
- Same-cycle write-to-read bypass, optional hardwired-zero register 0, asynchronous clear of the whole array.
- Sits between the decode stage (read) and the writeback stage (write) of the processor datapath.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- DEPTH, 16, number of registers; 2 <= DEPTH <= 2^ADDR_W.
- ADDR_W, 4, address width.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes.
- BE_W, DATA_W/8, derived; number of byte enables (not user-set).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_en  in  1  read request; samples both read addresses this edge.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  registered read data, port 1.
- rd_data2  out  DATA_W  registered read data, port 2.
- rd_valid  out  1  high the cycle after an accepted read.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address (independent of read addresses).
- wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  in  DATA_W  write data.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, all DEPTH registers=0, rd_data1=0, rd_data2=0, rd_valid=0, immediately and without a clock. First operation is accepted on the first rising edge with rst=0.
- Reset mid-operation: any in-flight read result and pending write are discarded. Outputs read 0 until a new read completes.
- Write: on a rising edge with wr_en=1, for each byte i with wr_be[i]=1, reg[wr_addr] byte i <= wr_data byte i. Bytes with wr_be[i]=0 are unchanged.
  - wr_en=1 with wr_be=0 is a no-op.
  - No write occurs when wr_en=0.
- Read: latency is 1 cycle. On a rising edge with rd_en=1:
  - rd_data1 <= value(rd_addr1), rd_data2 <= value(rd_addr2), rd_valid <= 1.
  - On a rising edge with rd_en=0: rd_data1 <= 0, rd_data2 <= 0, rd_valid <= 0.
- Bypass: value(a) is taken after the same-edge write is applied. If wr_en=1 and wr_addr==a, the returned word is the stored word with the enabled bytes replaced by wr_data bytes. Applies independently to each port; both ports may bypass the same write.
- Both read ports may use the same address; both return identical data.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - value(0)=0 always, including under bypass.
- ZERO_REG=0: register 0 is an ordinary register.
- Out of range (DEPTH < 2^ADDR_W, address >= DEPTH): writes are dropped, value()=0, no bypass.
- There is no back-pressure: every read and write is accepted in its cycle.
- Outputs are driven only from flops. There is no combinational path from any input to rd_data1, rd_data2 or rd_valid.

Test Plan:
1. Reset clear (defaults): write 0xBEEF to r5, assert rst between edges, then read r5 -> rd_data1=0x0000 asynchronously during rst. The read after release returns 0x0000 with rd_valid=1.
2. Byte enables: write r3=0x1234 with be=11, then write 0xABCD with be=01; read r3 -> 0x12CD. A following write with be=00 leaves r3=0x12CD.
3. Bypass: r7=0x00FF stored. On the same edge, write r7=0x5500 with be=10 and read rd_addr1=7, rd_addr2=7 -> both ports return 0x55FF next cycle with rd_valid=1.
4. Read gating: read r2 (0x0042) with rd_en=1, then rd_en=0 -> cycle 1 rd_data1=0x0042, rd_valid=1; cycle 2 rd_data1=0x0000, rd_valid=0.
5. ZERO_REG=1 (DATA_W=32, DEPTH=8): write r0=0xFFFFFFFF with be=1111 and read r0 on the same edge -> 0x00000000. Write r9=0x1 (out of range) -> no register changes and read r9 returns 0.
6. Dual port: write r1=0x1111, r15=0xF0F0; read addr1=1, addr2=15 -> rd_data1=0x1111, rd_data2=0xF0F0, one cycle after the rd_en edge.
